// File: rtl/controle_envase.sv
// controle_envase: bottle filling station sequencer.
// Drives conveyor, fill valve and cork sealer through a fixed per-bottle
// cycle; counts bottles (units within a dozen plus dozens) and cork stock.
// Optional build macro SENSOR_SYNC_EN: when defined, SENSOR_POS and START
// pass through two-flop synchronizers before the sequencer sees them.
module controle_envase #(
  parameter int FILL_CYCLES = 4,
  parameter int SEAL_CYCLES = 2,
  parameter int CORK_BATCH  = 5,
  parameter int CORK_MAX    = 20
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic       SENSOR_POS,
  input  logic       CORK_LOAD,
  output logic       MOTOR,
  output logic       VALVE,
  output logic       SEAL,
  output logic       ALARM,
  output logic [3:0] BOTTLE_COUNT,
  output logic [3:0] DOZEN_COUNT,
  output logic [4:0] CORK_STOCK,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVEY  = 3'd1,
    S_FILL    = 3'd2,
    S_SEAL    = 3'd3,
    S_RELEASE = 3'd4,
    S_ALARM   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [3:0] bottle_q, bottle_d;
  logic [3:0] dozen_q, dozen_d;
  logic [4:0] stock_q, stock_d;
  logic [6:0] stock_sum;
  logic       sens, start, seal_exit;

`ifdef SENSOR_SYNC_EN
  logic [1:0] sens_sync_q, sens_sync_d;
  logic [1:0] start_sync_q, start_sync_d;

  // shift the raw inputs into their synchronizer chains
  always_comb begin
    sens_sync_d  = {sens_sync_q[0], SENSOR_POS};
    start_sync_d = {start_sync_q[0], START};
  end

  // synchronizer flops, cleared by reset like all other state
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sens_sync_q  <= '0;
      start_sync_q <= '0;
    end else begin
      sens_sync_q  <= sens_sync_d;
      start_sync_q <= start_sync_d;
    end
  end

  assign sens  = sens_sync_q[1];
  assign start = start_sync_q[1];
`else
  assign sens  = SENSOR_POS;
  assign start = START;
`endif

  // seal finishes on the edge where its timer has run out
  assign seal_exit = (state_q == S_SEAL) && (timer_q == 4'd0);

  // next-state, timer, bottle counter and cork stock
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bottle_d = bottle_q;
    dozen_d  = dozen_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (stock_q != 5'd0) ? S_CONVEY : S_ALARM;
      end
      S_CONVEY: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (sens) begin
          state_d = S_FILL;
          timer_d = 4'(FILL_CYCLES - 1);
        end
      end
      S_FILL: begin
        if (timer_q == 4'd0) begin
          state_d = S_SEAL;
          timer_d = 4'(SEAL_CYCLES - 1);
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_SEAL: begin
        if (timer_q == 4'd0) begin
          state_d = S_RELEASE;
          if (bottle_q == 4'd11) begin
            bottle_d = 4'd0;
            dozen_d  = dozen_q + 4'd1;
          end else begin
            bottle_d = bottle_q + 4'd1;
          end
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_RELEASE: begin
        if (!sens) begin
          if (stock_q == 5'd0) state_d = S_ALARM;
          else if (start)      state_d = S_CONVEY;
          else                 state_d = S_IDLE;
        end
      end
      S_ALARM: begin
        if (stock_q != 5'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // load and consume both apply; result clipped to the magazine ceiling
    stock_sum = {2'b00, stock_q}
              + (CORK_LOAD ? 7'(CORK_BATCH) : 7'd0)
              - {6'd0, seal_exit};
    stock_d   = (stock_sum > 7'(CORK_MAX)) ? 5'(CORK_MAX) : stock_sum[4:0];
  end

  // state and counter registers, synchronous reset has top priority
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bottle_q <= '0;
      dozen_q  <= '0;
      stock_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bottle_q <= bottle_d;
      dozen_q  <= dozen_d;
      stock_q  <= stock_d;
    end
  end

  // Moore actuator decode from the state register only
  always_comb begin
    MOTOR = 1'b0;
    VALVE = 1'b0;
    SEAL  = 1'b0;
    ALARM = 1'b0;
    case (state_q)
      S_CONVEY, S_RELEASE: MOTOR = 1'b1;
      S_FILL:              VALVE = 1'b1;
      S_SEAL:              SEAL  = 1'b1;
      S_ALARM:             ALARM = 1'b1;
      default: ;
    endcase
  end

  assign STATE        = state_q;
  assign BOTTLE_COUNT = bottle_q;
  assign DOZEN_COUNT  = dozen_q;
  assign CORK_STOCK   = stock_q;

endmodule
